prog_clock_divider: RTL and testbench
=====================================

# prog_clock_divider

Parametrised multi-channel programmable clock divider, the successor to the fixed divide-by-2/4/8/16 counter. Each channel divides `clk` by a run-time programmable integer N (2..2^DIV_W-1, odd or even) and produces a registered divided clock plus a one-cycle tick at the period boundary. Divisors are loaded over a valid/ready config port and applied glitch-free at the channel's next period boundary. It sits beside the system clock source and feeds timing enables to downstream logic.

## Interface
- `NUM_CH`, 4: number of independent channels (1..16).
- `DIV_W`, 8: divisor width; max N = 2^DIV_W-1.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  global run; low freezes all counters and outputs.
- `resync`  in  1  one-cycle pulse; restarts every enabled channel at phase 0.
- `cfg_valid`  in  1  config request.
- `cfg_ready`  out  1  config accept; transfer when `cfg_valid & cfg_ready`.
- `cfg_ch`  in  CH_W = max(1,$clog2(NUM_CH))  target channel.
- `cfg_div`  in  DIV_W  new divisor N; N<2 disables the channel.
- `clk_out`  out  NUM_CH  divided clocks, registered.
- `tick`  out  NUM_CH  one-cycle pulse in last cycle of each period, registered.

## Operation
- Per channel: `div` (active N), `cnt` (0..N-1), `shadow`, `pending`.
- Reset: `div`=0 (disabled), `cnt`=0, `pending`=0, `clk_out`=0, `tick`=0, `cfg_ready`=1.
- Channel states: DISABLED (div<2), RUNNING, RUNNING_PENDING.
- DISABLED: `clk_out`=0, `tick`=0, `cnt`=0. Accepted N≥2 applied immediately → RUNNING, phase 0 next cycle. Accepted N<2 is a no-op.
- RUNNING, `en`=1: `cnt` increments, wraps N-1→0. For phase k=`cnt`: `clk_out`=(k < ceil(N/2)), `tick`=(k==N-1). Odd N: high ceil(N/2), low floor(N/2) cycles.
- Config accept on running channel: `shadow`←`cfg_div`, `pending`←1 → RUNNING_PENDING. At the cycle where `cnt` wraps (tick cycle), `div`←`shadow`, `pending`←0; new period starts at phase 0 with new N. If shadow<2, channel goes DISABLED at that boundary (outputs 0 next cycle).
- `cfg_ready` = ~`pending[cfg_ch]`; combinational from `cfg_ch` and registered `pending`. A second write to a pending channel stalls until the boundary.
- `en`=0: `cnt`, `clk_out`, `tick` hold; configs still accepted (DISABLED channels update `div`, RUNNING channels set pending, applied only once counting resumes and reaches wrap).
- `resync`=1 (takes precedence over `en`=0): every non-disabled channel's `cnt`←0 and phase 0 next cycle; any pending shadow is applied at the same time.
- Simultaneous accept and wrap on same channel: the wrap applies the old `shadow` (if pending) first; the new request is not accepted because `cfg_ready`=0 while pending; with no pending, the accept sets pending and applies at the following wrap.
- Reset mid-operation: all channels return to reset values next cycle; pending configs lost.

## Timing
- Registered outputs: phase k is visible on `clk_out`/`tick` in the cycle `cnt`=k.
- Config on DISABLED channel accepted at edge t: `clk_out`=1, phase 0 in cycle t+1.
- Config on RUNNING channel: effective from the cycle after the next `tick`; worst-case latency N_old cycles.
- `resync` at edge t: phase 0 in cycle t+1 on all running channels.
- Divided output period exactly N `clk` cycles, no runt pulses across divisor changes.

## Structure
- Package `clkdiv_pkg`: `MAX_CH`=16, helper function `ceil_half(N)`, channel state enum {DISABLED, RUNNING, RUNNING_PENDING}.
- Sub-module `clkdiv_channel` (one per channel, generate loop): counter, shadow, pending, output flops. Top holds config decode and `cfg_ready` mux.

## Test plan
- Reset, then N=2 on ch0 → `clk_out[0]` 1,0,1,0…; `tick[0]` every 2nd cycle coincident with low phase; other channels stay 0.
- N=5 on ch1 → `clk_out[1]` high 3, low 2; `tick[1]` high at phase 4 only; period 5.
- ch2 running N=4, write N=7 mid-period → `cfg_ready`=0 for ch2 until tick; second write stalls; first period after tick is 7 cycles, no short pulse.
- `en`=0 for 10 cycles mid-period → all outputs frozen; resume continues at same phase.
- Channels at N=3 and N=4 out of phase, pulse `resync` → both at phase 0 next cycle, both `clk_out`=1, ticks re-aligned to cycles 2 and 3.
- Write N=1 to running ch3 (N=6) → stops at next boundary, outputs 0; assert `rst` mid-run → all outputs 0, `cfg_ready`=1 next cycle.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the programmable multi-channel clock divider.
package clkdiv_pkg;

    localparam int MAX_CH = 16;

    typedef enum logic [1:0] {
        DISABLED,
        RUNNING,
        RUNNING_PENDING
    } ch_state_e;

    function automatic int unsigned ceil_half(input int unsigned n);
        return (n + 1) / 2;
    endfunction

    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: phase counter, shadow divisor and registered clk_out/tick.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             resync,
    input  logic             cfg_we,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             pending,
    output logic             clk_out,
    output logic             tick
);

    ch_state_e        state;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             last;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= '0;
            cnt_q     <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    always_comb begin
        div_d     = div_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        clk_out_d = 1'b0;
        tick_d    = 1'b0;
        last      = (cnt_q == div_q - DIV_W'(1));

        if (div_q < DIV_W'(2))
            state = DISABLED;
        else if (pending_q)
            state = RUNNING_PENDING;
        else
            state = RUNNING;

        case (state)
            DISABLED: begin
                if (cfg_we && (cfg_div >= DIV_W'(2))) begin
                    div_d = cfg_div;
                    cnt_d = '0;
                end
            end
            RUNNING, RUNNING_PENDING: begin
                // Wrap (or resync) commits the old shadow before a new request can set pending again.
                if (resync || (en && last)) begin
                    cnt_d = '0;
                    if (pending_q) begin
                        div_d     = shadow_q;
                        pending_d = 1'b0;
                    end
                end else if (en) begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
                if (cfg_we && !pending_q) begin
                    shadow_d  = cfg_div;
                    pending_d = 1'b1;
                end
            end
            default: ;
        endcase

        // Outputs are decoded from next state so phase k is visible in the cycle cnt_q == k.
        if (div_d >= DIV_W'(2)) begin
            clk_out_d = (cnt_d < DIV_W'(ceil_half(32'(div_d))));
            tick_d    = (cnt_d == div_d - DIV_W'(1));
        end
    end

    assign pending = pending_q;
    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider: config decode, cfg_ready mux and channel array.
module prog_clock_divider
    import clkdiv_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int DIV_W  = 8,
    localparam int CH_W   = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              resync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    logic [NUM_CH-1:0]      pending;
    logic [NUM_CH-1:0]      cfg_we;
    logic [(2**CH_W)-1:0]   pending_ext;
    logic                   accept;

    // Unused channel indices read as never-pending and match no channel.
    always_comb begin
        pending_ext               = '0;
        pending_ext[NUM_CH-1:0]   = pending;
        cfg_ready                 = ~pending_ext[cfg_ch];
        accept                    = cfg_valid & cfg_ready;
        cfg_we                    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (accept && (cfg_ch == CH_W'(i)))
                cfg_we[i] = 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clkdiv_channel #(
            .DIV_W(DIV_W)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .en     (en),
            .resync (resync),
            .cfg_we (cfg_we[g]),
            .cfg_div(cfg_div),
            .pending(pending[g]),
            .clk_out(clk_out[g]),
            .tick   (tick[g])
        );
    end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider with hand-computed expected phases.
module tb_prog_clock_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       resync;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic [3:0] clk_out;
    logic [3:0] tick;

    int checks = 0;
    int errors = 0;

    prog_clock_divider #(
        .NUM_CH(4),
        .DIV_W (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .resync   (resync),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_one(input logic [1:0] ch, input logic [7:0] dv);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_div   = dv;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; resync = 1'b0;
        cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
        step();
        step();
        rst = 1'b0;
        check("reset_clk_out", 32'(clk_out), 32'h0);
        check("reset_tick", 32'(tick), 32'h0);
        check("reset_ready", 32'(cfg_ready), 32'h1);

        // N=2 on ch0
        cfg_one(2'd0, 8'd2);
        check("n2_first_clk", 32'(clk_out), 32'h1);
        check("n2_first_tick", 32'(tick), 32'h0);
        for (int i = 1; i < 7; i++) begin
            step();
            check("n2_clk", 32'(clk_out), (i % 2 == 0) ? 32'h1 : 32'h0);
            check("n2_tick", 32'(tick), (i % 2 == 1) ? 32'h1 : 32'h0);
        end

        // N=5 on ch1
        do_reset();
        cfg_one(2'd1, 8'd5);
        for (int k = 0; k < 10; k++) begin
            check("n5_clk", 32'(clk_out[1]), ((k % 5) < 3) ? 32'h1 : 32'h0);
            check("n5_tick", 32'(tick[1]), ((k % 5) == 4) ? 32'h1 : 32'h0);
            check("n5_others", 32'({clk_out[3:2], clk_out[0]}), 32'h0);
            step();
        end

        // ch2 N=4, reprogram to 7 mid-period, second write 9 stalls
        do_reset();
        cfg_one(2'd2, 8'd4);
        step();
        check("rp_phase1_clk", 32'(clk_out[2]), 32'h1);
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd7;
        check("rp_ready_idle", 32'(cfg_ready), 32'h1);
        step();
        cfg_div = 8'd9;
        check("rp_ready_pending", 32'(cfg_ready), 32'h0);
        check("rp_phase2_clk", 32'(clk_out[2]), 32'h0);
        step();
        check("rp_phase3_tick", 32'(tick[2]), 32'h1);
        check("rp_ready_stall", 32'(cfg_ready), 32'h0);
        step();
        check("rp_new_p0_clk", 32'(clk_out[2]), 32'h1);
        check("rp_new_p0_tick", 32'(tick[2]), 32'h0);
        check("rp_ready_after_wrap", 32'(cfg_ready), 32'h1);
        step();
        cfg_valid = 1'b0;
        check("rp_second_pending", 32'(cfg_ready), 32'h0);
        for (int k = 1; k < 7; k++) begin
            check("rp_n7_clk", 32'(clk_out[2]), (k < 4) ? 32'h1 : 32'h0);
            check("rp_n7_tick", 32'(tick[2]), (k == 6) ? 32'h1 : 32'h0);
            step();
        end
        check("rp_n9_ready", 32'(cfg_ready), 32'h1);
        for (int k = 0; k < 9; k++) begin
            check("rp_n9_clk", 32'(clk_out[2]), (k < 5) ? 32'h1 : 32'h0);
            check("rp_n9_tick", 32'(tick[2]), (k == 8) ? 32'h1 : 32'h0);
            step();
        end

        // en=0 freeze at phase 2 of N=5
        do_reset();
        cfg_one(2'd0, 8'd5);
        step();
        step();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("freeze_clk", 32'(clk_out[0]), 32'h1);
            check("freeze_tick", 32'(tick[0]), 32'h0);
        end
        en = 1'b1;
        step();
        check("resume_p3_clk", 32'(clk_out[0]), 32'h0);
        check("resume_p3_tick", 32'(tick[0]), 32'h0);
        step();
        check("resume_p4_tick", 32'(tick[0]), 32'h1);
        step();
        check("resume_p0_clk", 32'(clk_out[0]), 32'h1);
        check("resume_p0_tick", 32'(tick[0]), 32'h0);

        // resync of N=3 (ch0) and N=4 (ch1) out of phase
        do_reset();
        cfg_one(2'd0, 8'd3);
        cfg_one(2'd1, 8'd4);
        step();
        check("pre_rs_clk", 32'(clk_out[1:0]), 32'h2);
        check("pre_rs_tick", 32'(tick[1:0]), 32'h1);
        resync = 1'b1;
        step();
        resync = 1'b0;
        check("rs_p0_clk", 32'(clk_out[1:0]), 32'h3);
        check("rs_p0_tick", 32'(tick[1:0]), 32'h0);
        step();
        check("rs_p1_clk", 32'(clk_out[1:0]), 32'h3);
        check("rs_p1_tick", 32'(tick[1:0]), 32'h0);
        step();
        check("rs_p2_clk", 32'(clk_out[1:0]), 32'h0);
        check("rs_p2_tick", 32'(tick[1:0]), 32'h1);
        step();
        check("rs_p3_clk", 32'(clk_out[1:0]), 32'h1);
        check("rs_p3_tick", 32'(tick[1:0]), 32'h2);

        // disable running ch3 (N=6) by writing N=1
        do_reset();
        cfg_one(2'd3, 8'd6);
        step();
        cfg_one(2'd3, 8'd1);
        check("dis_ready_pending", 32'(cfg_ready), 32'h0);
        check("dis_p2_clk", 32'(clk_out[3]), 32'h1);
        step();
        step();
        step();
        check("dis_p5_tick", 32'(tick[3]), 32'h1);
        check("dis_p5_clk", 32'(clk_out[3]), 32'h0);
        step();
        check("dis_off_clk", 32'(clk_out[3]), 32'h0);
        check("dis_off_tick", 32'(tick[3]), 32'h0);
        check("dis_off_ready", 32'(cfg_ready), 32'h1);
        step();
        check("dis_stays_off", 32'({clk_out, tick}), 32'h0);

        // N=0 on a disabled channel is a no-op
        cfg_one(2'd0, 8'd0);
        check("n0_noop_clk", 32'(clk_out[0]), 32'h0);
        step();
        check("n0_noop_tick", 32'(tick[0]), 32'h0);

        // N=255 boundary on ch2
        cfg_one(2'd2, 8'd255);
        check("n255_p0_clk", 32'(clk_out[2]), 32'h1);
        for (int k = 1; k < 255; k++) begin
            step();
            if (k == 127) check("n255_p127_clk", 32'(clk_out[2]), 32'h1);
            if (k == 128) check("n255_p128_clk", 32'(clk_out[2]), 32'h0);
            if (k == 253) check("n255_p253_tick", 32'(tick[2]), 32'h0);
            if (k == 254) check("n255_p254_tick", 32'(tick[2]), 32'h1);
        end

        // reset mid-run with a pending config
        do_reset();
        cfg_one(2'd0, 8'd2);
        cfg_one(2'd1, 8'd3);
        cfg_one(2'd1, 8'd7);
        check("mid_rst_pending", 32'(cfg_ready), 32'h0);
        rst = 1'b1;
        step();
        check("mid_rst_clk", 32'(clk_out), 32'h0);
        check("mid_rst_tick", 32'(tick), 32'h0);
        check("mid_rst_ready", 32'(cfg_ready), 32'h1);
        rst = 1'b0;
        step();
        step();
        check("post_rst_idle", 32'({clk_out, tick}), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
